// File: rtl/tile_pixel_scanner.sv
// Tile pixel scanner: queues tile origins, walks each TxT tile in raster order and
// emits every pixel that lies on the inner side of all three triangle edges.
module tile_pixel_scanner #(
  parameter int T          = 16,
  parameter int COORD_W    = 10,
  parameter int COEF_W     = 12,
  parameter int E_W        = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     tile_valid,
  input  logic [COORD_W-1:0]       tile_x,
  input  logic [COORD_W-1:0]       tile_y,
  input  logic                     tile_done,
  input  logic signed [COEF_W-1:0] a0,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [E_W-1:0]    c0,
  input  logic signed [E_W-1:0]    c1,
  input  logic signed [E_W-1:0]    c2,
  output logic                     frag_valid,
  output logic [COORD_W-1:0]       frag_x,
  output logic [COORD_W-1:0]       frag_y,
  input  logic                     frag_ready,
  output logic                     busy,
  output logic                     overflow,
  output logic                     done
);

  localparam int IW = $clog2(T);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = 2 * COORD_W;

  localparam logic [PW:0]          CNT_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]          CNT_ONE  = (PW+1)'(1'b1);
  localparam logic [PW:0]          CNT_FULL = {1'b1, {PW{1'b0}}};
  localparam logic [PW-1:0]        PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1'b1);
  localparam logic [IW-1:0]        IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]        IDX_ONE  = IW'(1'b1);
  localparam logic [IW-1:0]        IDX_LAST = {IW{1'b1}};
  localparam logic [COORD_W-1:0]   CRD_ZERO = {COORD_W{1'b0}};
  localparam logic signed [E_W-1:0] E_ZERO  = {E_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  function automatic logic signed [E_W-1:0] sext_coef(input logic signed [COEF_W-1:0] v);
    sext_coef = {{(E_W-COEF_W){v[COEF_W-1]}}, v};
  endfunction

  function automatic logic signed [E_W-1:0] zext_coord(input logic [COORD_W-1:0] v);
    zext_coord = {{(E_W-COORD_W){1'b0}}, v};
  endfunction

  // Edge function sign test; arithmetic wraps at E_W bits by design.
  function automatic logic edge_inside(input logic signed [COEF_W-1:0] a,
                                       input logic signed [COEF_W-1:0] b,
                                       input logic signed [E_W-1:0]    c,
                                       input logic signed [E_W-1:0]    x,
                                       input logic signed [E_W-1:0]    y);
    edge_inside = (sext_coef(a) * x + sext_coef(b) * y + c) >= E_ZERO;
  endfunction

  state_t               state_r, state_next_s;
  logic [TW-1:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [PW:0]          count_r, count_next_s;
  logic [COORD_W-1:0]   px_r, py_r, px_next_s, py_next_s;
  logic [IW-1:0]        i_r, j_r, i_next_s, j_next_s;
  logic                 frag_valid_r, fv_next_s;
  logic [COORD_W-1:0]   frag_x_r, frag_y_r, fx_next_s, fy_next_s;
  logic                 overflow_r, pending_r, done_r, busy_r;
  logic                 stall_s, fifo_full_s, pop_s, push_s, drop_s;
  logic [COORD_W:0]     pix_x_s, pix_y_s;
  logic signed [E_W-1:0] ex_s, ey_s;
  logic                 emit_s;
  logic                 pend_any_s, idle_next_s, done_next_s;

  // Current pixel coordinates, range test and coverage decision.
  always_comb begin
    pix_x_s = {1'b0, px_r} + {{(COORD_W+1-IW){1'b0}}, i_r};
    pix_y_s = {1'b0, py_r} + {{(COORD_W+1-IW){1'b0}}, j_r};
    ex_s    = zext_coord(pix_x_s[COORD_W-1:0]);
    ey_s    = zext_coord(pix_y_s[COORD_W-1:0]);
    emit_s  = !pix_x_s[COORD_W] && !pix_y_s[COORD_W] &&
              edge_inside(a0, b0, c0, ex_s, ey_s) &&
              edge_inside(a1, b1, c1, ex_s, ey_s) &&
              edge_inside(a2, b2, c2, ex_s, ey_s);
  end

  // Tile queue push/pop decisions; a full queue still accepts when it pops that cycle.
  always_comb begin
    stall_s     = frag_valid_r && !frag_ready;
    fifo_full_s = (count_r == CNT_FULL);
    pop_s       = (state_r == S_LOAD) && (count_r != CNT_ZERO);
    push_s      = start && tile_valid && (!fifo_full_s || pop_s);
    drop_s      = start && tile_valid && fifo_full_s && !pop_s;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Scan FSM next state, pixel walk and output stage.
  always_comb begin
    state_next_s = state_r;
    px_next_s    = px_r;
    py_next_s    = py_r;
    i_next_s     = i_r;
    j_next_s     = j_r;
    fv_next_s    = stall_s;
    fx_next_s    = frag_x_r;
    fy_next_s    = frag_y_r;
    case (state_r)
      S_IDLE: begin
        if (count_next_s != CNT_ZERO) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: begin
        px_next_s    = fifo_mem_r[rd_ptr_r][TW-1:COORD_W];
        py_next_s    = fifo_mem_r[rd_ptr_r][COORD_W-1:0];
        i_next_s     = IDX_ZERO;
        j_next_s     = IDX_ZERO;
        state_next_s = S_SCAN;
      end
      S_SCAN: begin
        if (stall_s) begin
          state_next_s = S_SCAN;
        end else begin
          if (emit_s) begin
            fv_next_s = 1'b1;
            fx_next_s = pix_x_s[COORD_W-1:0];
            fy_next_s = pix_y_s[COORD_W-1:0];
          end else begin
            fv_next_s = 1'b0;
          end
          if (i_r == IDX_LAST) begin
            i_next_s = IDX_ZERO;
            if (j_r == IDX_LAST) begin
              j_next_s = IDX_ZERO;
              if (count_next_s != CNT_ZERO) begin
                state_next_s = S_LOAD;
              end else begin
                state_next_s = S_IDLE;
              end
            end else begin
              j_next_s = j_r + IDX_ONE;
            end
          end else begin
            i_next_s = i_r + IDX_ONE;
          end
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Completion bookkeeping evaluated on next-state values so done/busy stay registered.
  always_comb begin
    pend_any_s  = pending_r || tile_done;
    idle_next_s = (count_next_s == CNT_ZERO) && (state_next_s == S_IDLE) && !fv_next_s;
    done_next_s = pend_any_s && idle_next_s;
  end

  // Control and datapath registers; start low behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst || !start) begin
      state_r      <= S_IDLE;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      px_r         <= CRD_ZERO;
      py_r         <= CRD_ZERO;
      i_r          <= IDX_ZERO;
      j_r          <= IDX_ZERO;
      frag_valid_r <= 1'b0;
      frag_x_r     <= CRD_ZERO;
      frag_y_r     <= CRD_ZERO;
      overflow_r   <= 1'b0;
      pending_r    <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r      <= count_next_s;
      px_r         <= px_next_s;
      py_r         <= py_next_s;
      i_r          <= i_next_s;
      j_r          <= j_next_s;
      frag_valid_r <= fv_next_s;
      frag_x_r     <= fx_next_s;
      frag_y_r     <= fy_next_s;
      overflow_r   <= overflow_r || drop_s;
      pending_r    <= pend_any_s && !done_next_s;
      done_r       <= done_next_s;
      busy_r       <= !idle_next_s;
    end
  end

  // Tile queue storage (data only; occupancy lives in the pointers and count).
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      fifo_mem_r[wr_ptr_r] <= {tile_x, tile_y};
    end
  end

  assign frag_valid = frag_valid_r;
  assign frag_x     = frag_x_r;
  assign frag_y     = frag_y_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign done       = done_r;

endmodule

// File: tb/tb_tile_pixel_scanner.sv
// Directed plus randomized bench for tile_pixel_scanner (T=4) against a
// coverage model built directly from the edge-function rules.
module tb_tile_pixel_scanner;

  localparam int T  = 4;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst, start, tile_valid, tile_done, frag_ready;
  logic [CW-1:0] tile_x, tile_y;
  logic signed [11:0] a0, a1, a2, b0, b1, b2;
  logic signed [25:0] c0, c1, c2;
  logic frag_valid, busy, overflow, done;
  logic [CW-1:0] frag_x, frag_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit rand_ready = 1'b0;
  logic [19:0] got_q[$];
  int          got_cyc_q[$];
  logic [19:0] exp_q[$];

  tile_pixel_scanner #(.T(T), .COORD_W(CW), .COEF_W(12), .E_W(26), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tile_valid(tile_valid), .tile_x(tile_x), .tile_y(tile_y), .tile_done(tile_done),
    .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2), .c0(c0), .c1(c1), .c2(c2),
    .frag_valid(frag_valid), .frag_x(frag_x), .frag_y(frag_y), .frag_ready(frag_ready),
    .busy(busy), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records accepted fragments and done pulses away from the active edge.
  always @(negedge clk) begin
    if (frag_valid && frag_ready) begin
      got_q.push_back({frag_x, frag_y});
      got_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) frag_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_tile(input int x, input int y, input bit last);
    tile_valid = 1'b1;
    tile_x     = 10'(x);
    tile_y     = 10'(y);
    tile_done  = last;
    push_cyc   = cyc + 1;
    step();
    tile_valid = 1'b0;
    tile_done  = 1'b0;
  endtask

  function automatic bit inside_edge(input longint a, input longint b, input longint c,
                                     input longint x, input longint y);
    return (a * x + b * y + c) >= 0;
  endfunction

  // Reference: every in-range pixel of the tile, raster order, inside all three edges.
  task automatic model_tile(input int tx, input int ty);
    for (int j = 0; j < T; j++) begin
      for (int i = 0; i < T; i++) begin
        int x, y;
        x = tx + i;
        y = ty + j;
        if (x <= 1023 && y <= 1023 &&
            inside_edge(a0, b0, c0, x, y) &&
            inside_edge(a1, b1, c1, x, y) &&
            inside_edge(a2, b2, c2, x, y))
          exp_q.push_back({10'(x), 10'(y)});
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk(tag, 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_cnt;
    for (int k = 0; k < budget && done_cnt == base; k++) step();
    chk("done_seen", done_cnt - base, 1);
  endtask

  task automatic clear_run();
    start = 1'b0;
    step();
    start = 1'b1;
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic zero_coefs();
    a0 = 12'sd0; a1 = 12'sd0; a2 = 12'sd0;
    b0 = 12'sd0; b1 = 12'sd0; b2 = 12'sd0;
    c0 = 26'sd0; c1 = 26'sd0; c2 = 26'sd0;
  endtask

  initial begin
    int base, bx, by, cx, cy;
    rst = 1'b0; start = 1'b0; tile_valid = 1'b0; tile_done = 1'b0; frag_ready = 1'b1;
    tile_x = 10'd0; tile_y = 10'd0;
    zero_coefs();
    repeat (3) step();
    chk("rst_frag_valid", 32'(frag_valid), 32'd0);
    chk("rst_frag_xy", 32'({frag_x, frag_y}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1; start = 1'b1;
    step(); step();
    chk("idle_busy", 32'(busy), 32'd0);

    // All-covered tile at origin: 16 back-to-back fragments, done one cycle later.
    clear_run();
    model_tile(0, 0);
    push_tile(0, 0, 1'b1);
    chk("a_busy", 32'(busy), 32'd1);
    wait_done(200);
    compare("a_frag");
    if (got_cyc_q.size() == 16) begin
      chk("a_first_cyc", got_cyc_q[0], push_cyc + 2);
      chk("a_last_cyc", got_cyc_q[15], push_cyc + 17);
      chk("a_done_cyc", done_cyc, got_cyc_q[15] + 1);
    end
    step();
    chk("a_busy_after", 32'(busy), 32'd0);

    // Half-plane x <= 1: tile (4,0) yields nothing, tile (0,0) yields x in {0,1}.
    clear_run();
    a0 = -12'sd1; c0 = 26'sd1;
    model_tile(4, 0);
    model_tile(0, 0);
    push_tile(4, 0, 1'b0);
    push_tile(0, 0, 1'b1);
    wait_done(200);
    compare("b_frag");
    chk("b_total", got_q.size(), 8);

    // Back-pressure for 5 cycles mid-scan: held fragment is the next one the model predicts.
    clear_run();
    zero_coefs();
    model_tile(0, 0);
    push_tile(0, 0, 1'b1);
    repeat (5) step();
    frag_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("c_hold_valid", 32'(frag_valid), 32'd1);
      if (got_q.size() < exp_q.size())
        chk("c_hold_xy", 32'({frag_x, frag_y}), 32'(exp_q[got_q.size()]));
      step();
    end
    frag_ready = 1'b1;
    wait_done(200);
    compare("c_frag");

    // Six tiles back to back with a blocked output: the sixth is dropped.
    clear_run();
    frag_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_tile(4 * k, 0, k == 4);
    chk("d_overflow", 32'(overflow), 32'd1);
    chk("d_busy", 32'(busy), 32'd1);
    repeat (10) step();
    chk("d_overflow_sticky", 32'(overflow), 32'd1);
    chk("d_held_first", 32'({frag_valid, frag_x, frag_y}), 32'({1'b1, 20'd0}));
    for (int k = 0; k < 5; k++) model_tile(4 * k, 0);
    frag_ready = 1'b1;
    wait_done(400);
    compare("d_frag");
    chk("d_overflow_end", 32'(overflow), 32'd1);
    clear_run();
    chk("d_overflow_cleared", 32'(overflow), 32'd0);

    // Tile straddling the right border: only x=1022,1023 survive.
    model_tile(1022, 0);
    push_tile(1022, 0, 1'b1);
    wait_done(200);
    compare("e_frag");
    chk("e_total", got_q.size(), 8);

    // One-cycle reset mid-scan with overflow set, then a fresh tile.
    clear_run();
    frag_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_tile(4 * k, 0, k == 4);
    frag_ready = 1'b1;
    repeat (6) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("f_rst_valid", 32'(frag_valid), 32'd0);
    chk("f_rst_busy", 32'(busy), 32'd0);
    chk("f_rst_overflow", 32'(overflow), 32'd0);
    chk("f_rst_xy", 32'({frag_x, frag_y}), 32'd0);
    step();
    chk("f_post_valid", 32'(frag_valid), 32'd0);
    chk("f_post_busy", 32'(busy), 32'd0);
    got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    model_tile(8, 4);
    push_tile(8, 4, 1'b1);
    wait_done(200);
    compare("f_frag");
    if (got_cyc_q.size() > 0) chk("f_first_cyc", got_cyc_q[0], push_cyc + 2);

    // Randomized edges, clustered tiles and random back-pressure.
    for (int r = 0; r < 4; r++) begin
      clear_run();
      bx = (r == 0) ? 1018 : int'($urandom_range(0, 1015));
      by = (r == 1) ? 1019 : int'($urandom_range(0, 1015));
      cx = bx + int'($urandom_range(0, 7));
      cy = by + int'($urandom_range(0, 7));
      a0 = 12'(int'($urandom_range(0, 127)) - 64);
      a1 = 12'(int'($urandom_range(0, 127)) - 64);
      a2 = 12'(int'($urandom_range(0, 127)) - 64);
      b0 = 12'(int'($urandom_range(0, 127)) - 64);
      b1 = 12'(int'($urandom_range(0, 127)) - 64);
      b2 = 12'(int'($urandom_range(0, 127)) - 64);
      c0 = 26'(-(longint'(a0) * cx + longint'(b0) * cy) + longint'($urandom_range(0, 400)) - 100);
      c1 = 26'(-(longint'(a1) * cx + longint'(b1) * cy) + longint'($urandom_range(0, 400)) - 100);
      c2 = 26'(-(longint'(a2) * cx + longint'(b2) * cy) + longint'($urandom_range(0, 400)) - 100);
      rand_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        int tx, ty;
        tx = bx + 4 * (k % 2);
        ty = by + 4 * (k / 2);
        if (tx > 1023) tx = 1023;
        if (ty > 1023) ty = 1023;
        model_tile(tx, ty);
        push_tile(tx, ty, k == 3);
      end
      wait_done(600);
      rand_ready = 1'b0;
      frag_ready = 1'b1;
      compare("g_frag");
      chk("g_overflow", 32'(overflow), 32'd0);
      base = done_cnt;
      repeat (5) step();
      chk("g_done_once", done_cnt, base);
      chk("g_idle_busy", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_pixel_scanner.md
TILE_PIXEL_SCANNER -- requirements
Module: tile_pixel_scanner

Interface
REQ-001 SHALL have parameter T, default 16, tile edge length in pixels (power of two, >=2).
REQ-002 SHALL have parameter COORD_W, default 10, pixel coordinate width.
REQ-003 SHALL have parameter COEF_W, default 12, signed edge A/B coefficient width.
REQ-004 SHALL have parameter E_W, default 26, signed edge value / C width; E_W >= COEF_W+COORD_W+3.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, tile queue depth (power of two).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-008 SHALL have port start, input, 1, level enable; low clears all state as reset.
REQ-009 SHALL have ports tile_valid/tile_x/tile_y, input, 1/COORD_W/COORD_W, tile origin pulse from tile evaluator, no backpressure.
REQ-010 SHALL have port tile_done, input, 1, one-cycle pulse: no further tiles for this triangle.
REQ-011 SHALL have ports a0,a1,a2,b0,b1,b2 (input, COEF_W, signed) and c0,c1,c2 (input, E_W, signed), edge coefficients, stable for whole triangle.
REQ-012 SHALL have ports frag_valid/frag_x/frag_y, output, 1/COORD_W/COORD_W, covered pixel.
REQ-013 SHALL have port frag_ready, input, 1, downstream accept.
REQ-014 SHALL have ports busy, overflow, done, output, 1 each: work pending; sticky tile drop; one-cycle completion pulse.

Function
REQ-015 SHALL push {tile_x,tile_y} into the tile FIFO when start && tile_valid && FIFO not full.
REQ-016 SHALL drop the tile and set overflow (sticky until reset/start low) on push to a full FIFO with no same-cycle pop; push with simultaneous pop on full SHALL be accepted.
REQ-017 SHALL implement FSM IDLE -> LOAD -> SCAN -> (LOAD if FIFO non-empty, else IDLE); LOAD pops one tile and sets px=tile_x, py=tile_y, i=j=0 (one cycle).
REQ-018 SHALL in SCAN evaluate one pixel per cycle in raster order (i 0..T-1 inner, j 0..T-1 outer), pixel (tile_x+i, tile_y+j), unless stalled.
REQ-019 SHALL compute Ek = ak*px + bk*py + ck with px,py zero-extended to signed, full E_W precision, no saturation.
REQ-020 SHALL treat a pixel as covered iff E0>=0 && E1>=0 && E2>=0.
REQ-021 SHALL skip (not emit) any pixel whose tile_x+i or tile_y+j exceeds 2^COORD_W-1 (computed at COORD_W+1 bits); no wrap-around.
REQ-022 SHALL register covered pixels into the output stage: frag_valid rises the cycle after evaluation; latency tile pop to first possible fragment = 2 cycles.
REQ-023 SHALL hold frag_valid/frag_x/frag_y stable while frag_valid && !frag_ready; SCAN SHALL stall only when the output stage is full and not being drained.
REQ-024 SHALL advance past uncovered pixels without emitting and without stalling.
REQ-025 SHALL leave SCAN after pixel (T-1,T-1); a tile always costs T*T scan cycles plus stalls.
REQ-026 SHALL latch tile_done into a pending flag; done SHALL pulse one cycle when pending && FIFO empty && FSM IDLE && !frag_valid, then clear pending.
REQ-027 SHALL drive busy = FIFO non-empty || FSM != IDLE || frag_valid.
REQ-028 SHALL accept tile_valid and tile_done in the same cycle; done follows that tile's completion.

Reset
REQ-029 SHALL, on rst low at a clock edge or start low, clear FIFO, FSM to IDLE, frag_valid=0, frag_x=frag_y=0, busy=0, overflow=0, done=0, pending=0, regardless of operation in progress.
REQ-030 SHALL discard in-flight fragments on mid-scan reset; no fragment SHALL appear the cycle after reset deasserts.

Verification (T=4)
REQ-031 all coefficients 0, frag_ready=1, tile (0,0) -> 16 fragments (0,0),(1,0)..(3,3) on consecutive cycles, first 2 cycles after push; done 1 cycle after last.
REQ-032 a0=-1,c0=1, other edges a=b=0,c=0, tile (4,0) -> 0 fragments; tile (0,0) -> 8 fragments, x in {0,1}.
REQ-033 frag_ready=0 for 5 cycles during scan -> frag_valid/x/y unchanged throughout, no fragment lost or duplicated.
REQ-034 frag_ready=0, 6 tile_valid pulses on consecutive cycles -> 1 in LOAD/SCAN, 4 queued, 6th dropped, overflow=1, stays 1.
REQ-035 tile origin (1022,0), COORD_W=10, all covered -> only x=1022,1023 emitted (8 fragments).
REQ-036 rst low for 1 cycle mid-scan -> next cycle frag_valid=0, busy=0, overflow=0; new tile rescans from (tile_x,tile_y).
